// File: rtl/cpu_bus_strobe.sv
// PHI2 edge detector and memory strobe generator for the 6502 bus, clocked by CLK_SRC.
// Also stretches slow-device cycles by pulling RDY low for WAIT_CYCLES whole PHI2 cycles.
`timescale 1ns/1ps

module cpu_bus_strobe #(
  parameter int SYNC_STAGES  = 2,
  parameter int STROBE_DELAY = 1,
  parameter int STROBE_WIDTH = 4,
  parameter int WAIT_CYCLES  = 1,
  parameter int CNT_W        = 8
) (
  input  logic CLK_SRC,
  input  logic RESET_N,
  input  logic PHI2,
  input  logic RW,
  input  logic CS_SLOW,
  output logic OE_N,
  output logic WE_N,
  output logic RDY,
  output logic CYCLE_START
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] DELAY_LAST = (STROBE_DELAY > 0) ? CNT_W'(STROBE_DELAY - 1) : '0;
  localparam logic [CNT_W-1:0] WIDTH_LAST = CNT_W'(STROBE_WIDTH - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   ps, pp, rise, fall;
  logic [CNT_W-1:0]       tick_cnt, str_cnt, wait_cnt;
  logic                   served;
  state_t                 state, next_state;
  logic                   rw_q, cs_q, rw_next, cs_next;
  logic                   oe_d, we_d;

  always_ff @(posedge CLK_SRC or negedge RESET_N) begin
    if (!RESET_N) begin
      sync <= '0;
      pp   <= 1'b0;
    end else begin
      sync <= (sync << 1) | SYNC_STAGES'(PHI2);
      pp   <= ps;
    end
  end

  assign ps   = sync[SYNC_STAGES-1];
  assign rise = ps & ~pp;
  assign fall = ~ps & pp;

  // tick_cnt measures time since the detected rise; str_cnt measures time spent strobing
  always_ff @(posedge CLK_SRC or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_cnt <= '0;
      str_cnt  <= '0;
    end else begin
      if (rise)
        tick_cnt <= '0;
      else if (ps && tick_cnt != '1)
        tick_cnt <= tick_cnt + ONE;
      str_cnt <= (state != STROBE || rise) ? '0 : str_cnt + ONE;
    end
  end

  always_ff @(posedge CLK_SRC or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      rw_q        <= 1'b1;
      cs_q        <= 1'b0;
      OE_N        <= 1'b1;
      WE_N        <= 1'b1;
      CYCLE_START <= 1'b0;
    end else begin
      state       <= next_state;
      rw_q        <= rw_next;
      cs_q        <= cs_next;
      OE_N        <= oe_d;
      WE_N        <= we_d;
      CYCLE_START <= rise;
    end
  end

  // A rise in any state restarts the cycle, which also recovers from PHI2 glitches
  always_comb begin
    next_state = state;
    rw_next    = rw_q;
    cs_next    = cs_q;
    if (rise) begin
      rw_next    = RW;
      cs_next    = CS_SLOW;
      next_state = (STROBE_DELAY == 0) ? STROBE : SETUP;
    end else begin
      case (state)
        SETUP: begin
          if (fall)
            next_state = IDLE;
          else if (tick_cnt == DELAY_LAST)
            next_state = STROBE;
        end
        STROBE: begin
          if (fall)
            next_state = IDLE;
          else if (str_cnt == WIDTH_LAST)
            next_state = HOLD;
        end
        HOLD: begin
          if (fall)
            next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Strobes are decoded from the next state so they line up with the STROBE state itself
  always_comb begin
    oe_d = ~((next_state == STROBE) & rw_next);
    we_d = ~((next_state == STROBE) & ~rw_next);
  end

  // served stops the CPU's repeated final cycle from loading a second round of waits
  always_ff @(posedge CLK_SRC or negedge RESET_N) begin
    if (!RESET_N) begin
      wait_cnt <= '0;
      served   <= 1'b0;
      RDY      <= 1'b1;
    end else begin
      if (rise && cs_next && !served && (WAIT_CYCLES > 0) && wait_cnt == '0) begin
        wait_cnt <= WAIT_LOAD;
        RDY      <= 1'b0;
      end else if (fall) begin
        if (wait_cnt != '0) begin
          wait_cnt <= wait_cnt - ONE;
          if (wait_cnt == ONE) begin
            RDY    <= 1'b1;
            served <= 1'b1;
          end
        end else if (RDY) begin
          served <= 1'b0;
        end
      end
    end
  end

endmodule
